// File: rtl/vga_display_window.sv
// Active-window gate for a VGA timing stream: generates pixel fetch requests inside a
// runtime-configurable window and realigns syncs/DE/RGB with the pixel source latency.
module vga_display_window #(
  parameter int REZ_MAX_WIDTH = 11,
  parameter int RGB_WIDTH     = 12,
  parameter int PIX_LAT       = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [REZ_MAX_WIDTH-1:0] Hcount,
  input  logic [REZ_MAX_WIDTH-1:0] Vcount,
  input  logic                     Hsync_in,
  input  logic                     Vsync_in,
  input  logic                     Cfg_valid,
  output logic                     Cfg_ready,
  input  logic [REZ_MAX_WIDTH-1:0] Cfg_Hstart,
  input  logic [REZ_MAX_WIDTH-1:0] Cfg_Hlen,
  input  logic [REZ_MAX_WIDTH-1:0] Cfg_Vstart,
  input  logic [REZ_MAX_WIDTH-1:0] Cfg_Vlen,
  output logic                     Cfg_applied,
  output logic                     Pix_req,
  output logic [REZ_MAX_WIDTH-1:0] Pix_x,
  output logic [REZ_MAX_WIDTH-1:0] Pix_y,
  input  logic [RGB_WIDTH-1:0]     Pix_rgb,
  output logic                     Hsync_out,
  output logic                     Vsync_out,
  output logic                     De_out,
  output logic [RGB_WIDTH-1:0]     RGB_out,
  output logic                     Frame_start
);

  localparam int W = REZ_MAX_WIDTH;
  localparam int D = PIX_LAT + 2;

  typedef enum logic {IDLE, PENDING} cfg_state_e;

  cfg_state_e     state_q;
  logic           cfg_ready_q, cfg_applied_q;
  logic [W-1:0]   hstart_q, hlen_q, vstart_q, vlen_q;
  logic [W-1:0]   sh_hstart_q, sh_hlen_q, sh_vstart_q, sh_vlen_q;

  logic           boundary, apply;
  logic [W-1:0]   eff_hstart, eff_hlen, eff_vstart, eff_vlen;
  logic [W:0]     hend, vend;
  logic           active;
  logic [W-1:0]   pix_x_d, pix_y_d;

  logic [D-1:0]   act_q, hs_q, vs_q, fs_q;
  logic [W-1:0]   pix_x_q, pix_y_q;
  logic [RGB_WIDTH-1:0] rgb_q;

  assign boundary = (Hcount == '0) && (Vcount == '0);
  assign apply    = (state_q == PENDING) && boundary;

  // The boundary cycle itself already compares against the incoming window, so the
  // whole frame (starting at pixel 0,0) sees a single window.
  always_comb begin
    eff_hstart = apply ? sh_hstart_q : hstart_q;
    eff_hlen   = apply ? sh_hlen_q   : hlen_q;
    eff_vstart = apply ? sh_vstart_q : vstart_q;
    eff_vlen   = apply ? sh_vlen_q   : vlen_q;
    hend       = {1'b0, eff_hstart} + {1'b0, eff_hlen};
    vend       = {1'b0, eff_vstart} + {1'b0, eff_vlen};
    active     = (Hcount >= eff_hstart) && ({1'b0, Hcount} < hend) &&
                 (Vcount >= eff_vstart) && ({1'b0, Vcount} < vend);
    pix_x_d    = '0;
    pix_y_d    = '0;
    if (active) begin
      pix_x_d = Hcount - eff_hstart;
      pix_y_d = Vcount - eff_vstart;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= IDLE;
      cfg_ready_q   <= 1'b1;
      cfg_applied_q <= 1'b0;
      hstart_q      <= '0;
      hlen_q        <= W'(640);
      vstart_q      <= '0;
      vlen_q        <= W'(480);
      sh_hstart_q   <= '0;
      sh_hlen_q     <= W'(640);
      sh_vstart_q   <= '0;
      sh_vlen_q     <= W'(480);
    end else begin
      cfg_applied_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Cfg_valid) begin
            sh_hstart_q <= Cfg_Hstart;
            sh_hlen_q   <= Cfg_Hlen;
            sh_vstart_q <= Cfg_Vstart;
            sh_vlen_q   <= Cfg_Vlen;
            cfg_ready_q <= 1'b0;
            state_q     <= PENDING;
          end
        end
        PENDING: begin
          if (boundary) begin
            hstart_q      <= sh_hstart_q;
            hlen_q        <= sh_hlen_q;
            vstart_q      <= sh_vstart_q;
            vlen_q        <= sh_vlen_q;
            cfg_applied_q <= 1'b1;
            cfg_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // act_q[0] is the registered request; tap PIX_LAT lines up with the returning pixel.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      act_q   <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      fs_q    <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      rgb_q   <= '0;
    end else begin
      act_q   <= {act_q[D-2:0], active};
      hs_q    <= {hs_q[D-2:0], Hsync_in};
      vs_q    <= {vs_q[D-2:0], Vsync_in};
      fs_q    <= {fs_q[D-2:0], boundary};
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      rgb_q   <= act_q[PIX_LAT] ? Pix_rgb : '0;
    end
  end

  assign Cfg_ready   = cfg_ready_q;
  assign Cfg_applied = cfg_applied_q;
  assign Pix_req     = act_q[0];
  assign Pix_x       = pix_x_q;
  assign Pix_y       = pix_y_q;
  assign Hsync_out   = hs_q[D-1];
  assign Vsync_out   = vs_q[D-1];
  assign De_out      = act_q[D-1];
  assign Frame_start = fs_q[D-1];
  assign RGB_out     = rgb_q;

endmodule

// File: tb/tb_vga_display_window.sv
// Directed plus randomized bench for vga_display_window against a cycle-indexed
// behavioural window/config model.
module tb_vga_display_window;

  localparam int W   = 11;
  localparam int RW  = 12;
  localparam int LAT = 2;
  localparam int HN  = 4096;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [W-1:0]  Hcount, Vcount;
  logic          Hsync_in, Vsync_in;
  logic          Cfg_valid, Cfg_ready, Cfg_applied;
  logic [W-1:0]  Cfg_Hstart, Cfg_Hlen, Cfg_Vstart, Cfg_Vlen;
  logic          Pix_req;
  logic [W-1:0]  Pix_x, Pix_y;
  logic [RW-1:0] Pix_rgb, RGB_out;
  logic          Hsync_out, Vsync_out, De_out, Frame_start;

  vga_display_window #(.REZ_MAX_WIDTH(W), .RGB_WIDTH(RW), .PIX_LAT(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Hcount(Hcount), .Vcount(Vcount),
    .Hsync_in(Hsync_in), .Vsync_in(Vsync_in),
    .Cfg_valid(Cfg_valid), .Cfg_ready(Cfg_ready),
    .Cfg_Hstart(Cfg_Hstart), .Cfg_Hlen(Cfg_Hlen), .Cfg_Vstart(Cfg_Vstart), .Cfg_Vlen(Cfg_Vlen),
    .Cfg_applied(Cfg_applied), .Pix_req(Pix_req), .Pix_x(Pix_x), .Pix_y(Pix_y),
    .Pix_rgb(Pix_rgb), .Hsync_out(Hsync_out), .Vsync_out(Vsync_out), .De_out(De_out),
    .RGB_out(RGB_out), .Frame_start(Frame_start)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: applied window, pending window, per-cycle history.
  int w_hs, w_hl, w_vs, w_vl;
  int s_hs, s_hl, s_vs, s_vl;
  bit pending;
  int n = 0;
  bit act_h [HN];
  bit hs_h  [HN];
  bit vs_h  [HN];
  bit fs_h  [HN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    w_hs = 0; w_hl = 640; w_vs = 0; w_vl = 480;
    s_hs = 0; s_hl = 640; s_vs = 0; s_vl = 480;
    pending = 1'b0;
    for (int i = 0; i < HN; i++) begin
      act_h[i] = 1'b0; hs_h[i] = 1'b0; vs_h[i] = 1'b0; fs_h[i] = 1'b0;
    end
  endtask

  task automatic step(input int h, input int v, input bit hsi, input bit vsi,
                      input bit cv, input int ch, input int cl, input int cvs, input int cvl);
    bit pend0, applied, act, fs;
    int px, py, k;
    logic [RW-1:0] rgb;
    Hcount = W'(h); Vcount = W'(v); Hsync_in = hsi; Vsync_in = vsi;
    Cfg_valid = cv; Cfg_Hstart = W'(ch); Cfg_Hlen = W'(cl);
    Cfg_Vstart = W'(cvs); Cfg_Vlen = W'(cvl);
    rgb = RW'($urandom);
    Pix_rgb = rgb;

    fs = (h == 0) && (v == 0);
    pend0 = pending;
    applied = 1'b0;
    if (fs && pending) begin
      w_hs = s_hs; w_hl = s_hl; w_vs = s_vs; w_vl = s_vl;
      pending = 1'b0;
      applied = 1'b1;
    end
    act = (h >= w_hs) && (h < w_hs + w_hl) && (v >= w_vs) && (v < w_vs + w_vl);
    px = act ? h - w_hs : 0;
    py = act ? v - w_vs : 0;
    if (!pend0 && cv) begin
      s_hs = ch; s_hl = cl; s_vs = cvs; s_vl = cvl;
      pending = 1'b1;
    end
    act_h[n] = act; hs_h[n] = hsi; vs_h[n] = vsi; fs_h[n] = fs;

    @(posedge Clk); #1;
    k = n - LAT - 1;
    chk("pix_req", 32'(Pix_req), 32'(act));
    chk("pix_x", 32'(Pix_x), 32'(px));
    chk("pix_y", 32'(Pix_y), 32'(py));
    chk("cfg_ready", 32'(Cfg_ready), 32'(!pending));
    chk("cfg_applied", 32'(Cfg_applied), 32'(applied));
    chk("de_out", 32'(De_out), (k >= 0) ? 32'(act_h[k]) : 32'd0);
    chk("hsync_out", 32'(Hsync_out), (k >= 0) ? 32'(hs_h[k]) : 32'd0);
    chk("vsync_out", 32'(Vsync_out), (k >= 0) ? 32'(vs_h[k]) : 32'd0);
    chk("frame_start", 32'(Frame_start), (k >= 0) ? 32'(fs_h[k]) : 32'd0);
    chk("rgb_out", 32'(RGB_out), (k >= 0 && act_h[k]) ? 32'(rgb) : 32'd0);
    n++;
  endtask

  task automatic idle_step(input int h, input int v);
    step(h, v, 1'($urandom), 1'($urandom), 1'b0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_req"}, 32'(Pix_req), 32'd0);
    chk({tag, "_pix_x"}, 32'(Pix_x), 32'd0);
    chk({tag, "_de"}, 32'(De_out), 32'd0);
    chk({tag, "_rgb"}, 32'(RGB_out), 32'd0);
    chk({tag, "_syncs"}, 32'({Hsync_out, Vsync_out, Frame_start}), 32'd0);
    chk({tag, "_applied"}, 32'(Cfg_applied), 32'd0);
  endtask

  initial begin
    int h, v, ch, cl, cvs, cvl;
    bit cv;
    Rst = 1'b0; Hcount = '0; Vcount = '0; Hsync_in = 1'b0; Vsync_in = 1'b0;
    Cfg_valid = 1'b0; Cfg_Hstart = '0; Cfg_Hlen = '0; Cfg_Vstart = '0; Cfg_Vlen = '0;
    Pix_rgb = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_outputs("reset");
    Rst = 1'b1;
    #1;
    chk("reset_cfg_ready", 32'(Cfg_ready), 32'd1);

    // Default window: (0,0) request, then DE/frame start four cycles on
    step(0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    chk("dflt_pix_req", 32'(Pix_req), 32'd1);
    idle_step(700, 600);
    idle_step(700, 600);
    idle_step(700, 600);
    chk("dflt_de", 32'(De_out), 32'd1);
    chk("dflt_frame_start", 32'(Frame_start), 32'd1);

    // Right edge of the default window
    idle_step(639, 10);
    chk("edge_pix_x", 32'(Pix_x), 32'd639);
    idle_step(640, 10);
    chk("edge_pix_req_off", 32'(Pix_req), 32'd0);
    repeat (4) idle_step(641, 10);

    // Mid-frame config, applied at the next boundary
    step(300, 200, 1'b0, 1'b0, 1'b1, 144, 800, 35, 600);
    chk("cfg_ready_drop", 32'(Cfg_ready), 32'd0);
    idle_step(310, 200);
    idle_step(0, 0);
    chk("cfg_applied_pulse", 32'(Cfg_applied), 32'd1);
    idle_step(144, 35);
    chk("new_win_req", 32'(Pix_req), 32'd1);
    chk("new_win_xy", 32'({Pix_x, Pix_y}), 32'd0);
    idle_step(943, 634);
    idle_step(944, 634);

    // Capture on a boundary waits one frame; a second request while pending is ignored
    step(0, 0, 1'b0, 1'b0, 1'b1, 10, 20, 10, 20);
    step(5, 5, 1'b0, 1'b0, 1'b1, 0, 5, 0, 5);
    idle_step(12, 12);
    idle_step(0, 0);
    chk("boundary_cfg_applied", 32'(Cfg_applied), 32'd1);
    idle_step(29, 29);
    idle_step(3, 3);

    // Zero width window: nothing active, syncs keep flowing
    step(1, 1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 480);
    idle_step(0, 0);
    for (int i = 0; i < 20; i++) idle_step(1 + $urandom_range(0, 700), $urandom_range(0, 500));

    // Randomized traffic, including no-wrap windows near the top of the range
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: begin h = $urandom_range(0, 2047); v = $urandom_range(0, 2047); end
        1: begin h = w_hs + w_hl + $urandom_range(0, 3) - 2;
                 v = w_vs + $urandom_range(0, 3) - 1; end
        2: begin h = w_hs + $urandom_range(0, 3) - 1;
                 v = w_vs + w_vl + $urandom_range(0, 3) - 2; end
        default: begin h = 0; v = 0; end
      endcase
      if (h < 0) h = 0;
      if (h > 2047) h = 2047;
      if (v < 0) v = 0;
      if (v > 2047) v = 2047;
      cv  = ($urandom_range(0, 7) == 0);
      ch  = $urandom_range(0, 2047);
      cl  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 2047);
      cvs = $urandom_range(0, 2047);
      cvl = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 2047);
      step(h, v, 1'($urandom), 1'($urandom), cv, ch, cl, cvs, cvl);
    end

    // Reset while a config is pending discards it
    while (pending) idle_step(0, 0);
    step(100, 100, 1'b1, 1'b1, 1'b1, 50, 60, 70, 80);
    idle_step(0, 0);
    idle_step(700, 600);
    step(100, 100, 1'b1, 1'b1, 1'b1, 50, 60, 70, 80);
    chk("pre_reset_pending", 32'(Cfg_ready), 32'd0);
    #2;
    Rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge Clk); #1;
    Rst = 1'b1;
    model_reset();
    #1;
    chk("midreset_cfg_ready", 32'(Cfg_ready), 32'd1);
    idle_step(0, 0);
    chk("midreset_no_apply", 32'(Cfg_applied), 32'd0);
    idle_step(639, 479);
    chk("midreset_default_win", 32'({Pix_x, Pix_y}), {10'd0, 11'd639, 11'd479});
    for (int i = 0; i < 10; i++) idle_step($urandom_range(0, 800), $urandom_range(0, 600));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
